axi4lite_master_q: RTL and testbench
====================================

Name: axi4lite_master_q

Overview:
- Parametrised AXI4-Lite master; successor of the single-shot enable-driven master.
- Accepts read and write commands on independent valid/ready request ports. Drives fully AXI-compliant AW/W/B and AR/R handshakes, with AW and W tracked independently.
- Returns per-transaction responses (RRESP/BRESP) and flags transactions that run past a programmable watchdog.
- Sits between local control logic (register sequencers, DMA setup) and the AXI interconnect.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width of request ports and AxADDR.
- C_M_AXI_DATA_WIDTH, 32, data width; legal values 32 or 64; strobe width is DATA_WIDTH/8.
- C_TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog.
- C_AXI_PROT, 3'b000, constant driven on AWPROT/ARPROT.

Ports:
- m_axi_aclk  in  1  clock
- m_axi_aresetn  in  1  synchronous active-low reset
- wr_req_valid  in  1  write command valid
- wr_req_ready  out  1  write command accepted when valid&ready
- wr_req_addr  in  ADDR  write address
- wr_req_data  in  DATA  write data
- wr_req_strb  in  DATA/8  byte strobes
- wr_rsp_valid  out  1  one-cycle pulse: write complete
- wr_rsp_resp  out  2  BRESP of completed write
- wr_timeout  out  1  one-cycle pulse: write exceeded watchdog
- rd_req_valid  in  1  read command valid
- rd_req_ready  out  1  read command accepted
- rd_req_addr  in  ADDR  read address
- rd_rsp_valid  out  1  one-cycle pulse: read complete
- rd_rsp_data  out  DATA  read data, held until next rd_rsp_valid
- rd_rsp_resp  out  2  RRESP, held with data
- rd_timeout  out  1  one-cycle pulse: read exceeded watchdog
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in
- M_AXI_BRESP/BVALID in, BREADY out
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in
- M_AXI_RDATA/RRESP/RVALID in, RREADY out

Behaviour:
- Reset: synchronous on the rising edge with m_axi_aresetn=0. All AXI VALID/READY, rsp_valid, timeout, addr, data, strb and resp outputs are 0. Both FSMs go to IDLE. Any in-flight transaction is abandoned silently.
- Write FSM: W_IDLE, W_XFER, W_RESP.
  - W_IDLE: wr_req_ready=1 (combinational from state). On accept, register addr/data/strb and set AWVALID=WVALID=1 next cycle (W_XFER).
  - W_XFER: AWVALID drops the cycle after AWVALID&AWREADY. WVALID drops the cycle after WVALID&WREADY. The two handshakes may complete in either order or in the same cycle. AWADDR, WDATA and WSTRB are held stable while their VALID is high. When both are done, go to W_RESP with BREADY=1.
  - W_RESP: on BVALID&BREADY, go to W_IDLE with BREADY=0. wr_rsp_valid=1 for one cycle, with wr_rsp_resp=BRESP, in the first W_IDLE cycle.
  - A new command may be accepted in the same cycle as wr_rsp_valid.
  - Minimum latency is accept to wr_rsp_valid = 3 cycles, with zero-wait slave.
- Read FSM: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: rd_req_ready=1. On accept, ARADDR is latched and ARVALID=1 next cycle (R_ADDR).
  - R_ADDR: on ARREADY, ARVALID=0 and RREADY=1 (R_DATA).
  - R_DATA: on RVALID, capture RDATA/RRESP, RREADY=0, go to R_IDLE. rd_rsp_valid pulses in the first R_IDLE cycle.
  - Minimum latency is 3 cycles.
- Read and write paths are fully independent and may run concurrently. There is no ordering between them.
- Watchdog (per path, 16-bit+ counter sized by $clog2(C_TIMEOUT_CYCLES+1)):
  - Cleared on accept; increments each non-IDLE cycle.
  - When the count equals C_TIMEOUT_CYCLES, *_timeout pulses once and the counter saturates. No second pulse occurs for the same transaction.
  - The transaction is not aborted; the FSM keeps waiting, since AXI forbids retracting VALID.
  - With C_TIMEOUT_CYCLES=0, the counter is absent and *_timeout is tied to 0.
- Request inputs are ignored when ready=0. Requests need not be held after acceptance.
- AXI VALID signals never depend combinationally on AXI READY inputs.

Decomposition:
- Package axi4lite_pkg holds:
  - FSM state localparams (W_IDLE/W_XFER/W_RESP, R_IDLE/R_ADDR/R_DATA).
  - RESP encodings: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - PROT default.
- Sub-module axi4lite_watchdog, parameter C_TIMEOUT_CYCLES, ports clr/run/timeout_pulse. Instantiated once per path.

Test Plan:
1. Zero-wait slave, write addr 0x10, data 0xDEADBEEF, strb 0xF.
   - AW and W valid in cycle 1, BREADY in cycle 2.
   - wr_rsp_valid in cycle 3 with resp 2'b00.
2. Slave asserts WREADY 2 cycles before AWREADY (addr 0x20).
   - WVALID drops first; AWADDR is held at 0x20 until AWREADY.
   - A single wr_rsp_valid follows.
3. Read addr 0x40, RVALID after 5 cycles with RDATA 0x12345678 and RRESP 2'b10.
   - One rd_rsp_valid; rd_rsp_data=0x12345678 and rd_rsp_resp=2'b10 are held afterwards.
4. Concurrent write (0x04) and read (0x08) issued in the same cycle.
   - Both complete independently; each rsp pulses exactly once.
5. C_TIMEOUT_CYCLES=8, slave withholds BVALID for 20 cycles.
   - wr_timeout pulses exactly once, 8 cycles after accept.
   - wr_rsp_valid follows later, once BVALID arrives.
6. Reset asserted while in W_XFER.
   - Next cycle: all VALID/READY are 0, wr_req_ready=1, and no rsp pulse is emitted.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// ----------------------------------------------------------------------------
// axi4lite_pkg : shared FSM encodings and AXI response/protection constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi4lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

`default_nettype wire

// File: rtl/axi4lite_watchdog.sv
// ----------------------------------------------------------------------------
// axi4lite_watchdog : per-transaction cycle counter with a single timeout pulse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi4lite_watchdog #(
  parameter int unsigned C_TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic timeout_pulse
);

  generate
    if (C_TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused      = &{1'b0, clk, rst_n, clr, run};
      assign timeout_pulse = 1'b0;
    end else begin : g_on
      localparam int unsigned C_CLOG = $clog2(C_TIMEOUT_CYCLES + 1);
      localparam int unsigned C_CNT_W = (C_CLOG > 16) ? C_CLOG : 16;
      localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(C_TIMEOUT_CYCLES);

      logic [C_CNT_W-1:0] r_cnt;
      logic               r_pulse;

      // Saturating at the limit is what guarantees one pulse per transaction.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_pulse <= 1'b0;
        end else begin
          r_pulse <= 1'b0;
          if (clr) begin
            r_cnt <= '0;
          end else if (run && (r_cnt != C_LIMIT)) begin
            r_cnt   <= r_cnt + 1'b1;
            r_pulse <= (r_cnt == (C_LIMIT - 1'b1));
          end
        end
      end

      assign timeout_pulse = r_pulse;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/axi4lite_master_q.sv
// ----------------------------------------------------------------------------
// axi4lite_master_q : queued-command AXI4-Lite master, independent read/write
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi4lite_master_q
  import axi4lite_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024,
  parameter logic [2:0]  C_AXI_PROT         = PROT_DEFAULT
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic                              wr_req_valid,
  output logic                              wr_req_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     wr_req_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_req_data,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wr_req_strb,
  output logic                              wr_rsp_valid,
  output logic [1:0]                        wr_rsp_resp,
  output logic                              wr_timeout,
  input  logic                              rd_req_valid,
  output logic                              rd_req_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     rd_req_addr,
  output logic                              rd_rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rd_rsp_data,
  output logic [1:0]                        rd_rsp_resp,
  output logic                              rd_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned C_STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;

  wr_state_e                       r_w_state;
  logic                            r_awvalid;
  logic                            r_wvalid;
  logic                            r_bready;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [C_STRB_WIDTH-1:0]         r_wstrb;
  logic                            r_wr_rsp_valid;
  logic [1:0]                      r_wr_rsp_resp;

  rd_state_e                       r_r_state;
  logic                            r_arvalid;
  logic                            r_rready;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
  logic                            r_rd_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rd_rsp_data;
  logic [1:0]                      r_rd_rsp_resp;

  logic w_wr_accept;
  logic w_rd_accept;

  assign w_wr_accept = (r_w_state == W_IDLE) && wr_req_valid;
  assign w_rd_accept = (r_r_state == R_IDLE) && rd_req_valid;

  // AW and W retire independently; BREADY rises once both have handshaked.
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      r_w_state      <= W_IDLE;
      r_awvalid      <= 1'b0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
      r_awaddr       <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_wr_rsp_valid <= 1'b0;
      r_wr_rsp_resp  <= OKAY;
    end else begin
      r_wr_rsp_valid <= 1'b0;
      case (r_w_state)
        W_IDLE: begin
          if (wr_req_valid) begin
            r_awaddr  <= wr_req_addr;
            r_wdata   <= wr_req_data;
            r_wstrb   <= wr_req_strb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_w_state <= W_XFER;
          end
        end
        W_XFER: begin
          if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
          if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
            r_bready  <= 1'b1;
            r_w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready       <= 1'b0;
            r_wr_rsp_valid <= 1'b1;
            r_wr_rsp_resp  <= M_AXI_BRESP;
            r_w_state      <= W_IDLE;
          end
        end
        default: r_w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      r_r_state      <= R_IDLE;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_araddr       <= '0;
      r_rd_rsp_valid <= 1'b0;
      r_rd_rsp_data  <= '0;
      r_rd_rsp_resp  <= OKAY;
    end else begin
      r_rd_rsp_valid <= 1'b0;
      case (r_r_state)
        R_IDLE: begin
          if (rd_req_valid) begin
            r_araddr  <= rd_req_addr;
            r_arvalid <= 1'b1;
            r_r_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready       <= 1'b0;
            r_rd_rsp_valid <= 1'b1;
            r_rd_rsp_data  <= M_AXI_RDATA;
            r_rd_rsp_resp  <= M_AXI_RRESP;
            r_r_state      <= R_IDLE;
          end
        end
        default: r_r_state <= R_IDLE;
      endcase
    end
  end

  axi4lite_watchdog #(
    .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
  ) u_wr_wdog (
    .clk           (m_axi_aclk),
    .rst_n         (m_axi_aresetn),
    .clr           (w_wr_accept),
    .run           (r_w_state != W_IDLE),
    .timeout_pulse (wr_timeout)
  );

  axi4lite_watchdog #(
    .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
  ) u_rd_wdog (
    .clk           (m_axi_aclk),
    .rst_n         (m_axi_aresetn),
    .clr           (w_rd_accept),
    .run           (r_r_state != R_IDLE),
    .timeout_pulse (rd_timeout)
  );

  assign wr_req_ready  = (r_w_state == W_IDLE);
  assign wr_rsp_valid  = r_wr_rsp_valid;
  assign wr_rsp_resp   = r_wr_rsp_resp;
  assign rd_req_ready  = (r_r_state == R_IDLE);
  assign rd_rsp_valid  = r_rd_rsp_valid;
  assign rd_rsp_data   = r_rd_rsp_data;
  assign rd_rsp_resp   = r_rd_rsp_resp;

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWPROT  = C_AXI_PROT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARPROT  = C_AXI_PROT;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_master_q.sv
// ----------------------------------------------------------------------------
// tb_axi4lite_master_q : scoreboard bench with a configurable-delay AXI4-Lite slave
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_axi4lite_master_q;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn;
  logic        wr_req_valid, wr_req_ready;
  logic [31:0] wr_req_addr, wr_req_data;
  logic [3:0]  wr_req_strb;
  logic        wr_rsp_valid, wr_timeout;
  logic [1:0]  wr_rsp_resp;
  logic        rd_req_valid, rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_rsp_valid, rd_timeout;
  logic [31:0] rd_rsp_data;
  logic [1:0]  rd_rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  axi4lite_master_q #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_TIMEOUT_CYCLES   (TO),
    .C_AXI_PROT         (3'b000)
  ) dut (
    .m_axi_aclk    (clk),           .m_axi_aresetn (aresetn),
    .wr_req_valid  (wr_req_valid),  .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),   .wr_req_data   (wr_req_data),
    .wr_req_strb   (wr_req_strb),   .wr_rsp_valid  (wr_rsp_valid),
    .wr_rsp_resp   (wr_rsp_resp),   .wr_timeout    (wr_timeout),
    .rd_req_valid  (rd_req_valid),  .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),   .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_data   (rd_rsp_data),   .rd_rsp_resp   (rd_rsp_resp),
    .rd_timeout    (rd_timeout),
    .M_AXI_AWADDR  (M_AXI_AWADDR),  .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),   .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),  .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),   .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),  .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),   .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),  .M_AXI_RREADY  (M_AXI_RREADY)
  );

  typedef struct { logic [1:0] resp; int lat; int acc; } wrsp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; int lat; int acc; } rrsp_t;

  logic [31:0] awq[$];
  logic [35:0] wq[$];
  logic [31:0] arq[$];
  wrsp_t       wrspq[$];
  rrsp_t       rrspq[$];
  int          wtoq[$];
  int          rtoq[$];

  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  initial begin
    int n;
    n = 0; M_AXI_AWREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_AWVALID && !M_AXI_AWREADY) begin
        if (n >= aw_delay) begin M_AXI_AWREADY = 1'b1; n = 0; end else n++;
      end else begin M_AXI_AWREADY = 1'b0; n = 0; end
    end
  end

  initial begin
    int n;
    n = 0; M_AXI_WREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_WVALID && !M_AXI_WREADY) begin
        if (n >= w_delay) begin M_AXI_WREADY = 1'b1; n = 0; end else n++;
      end else begin M_AXI_WREADY = 1'b0; n = 0; end
    end
  end

  initial begin
    int n;
    n = 0; M_AXI_ARREADY = 1'b0;
    forever begin
      @(negedge clk);
      if (M_AXI_ARVALID && !M_AXI_ARREADY) begin
        if (n >= ar_delay) begin M_AXI_ARREADY = 1'b1; n = 0; end else n++;
      end else begin M_AXI_ARREADY = 1'b0; n = 0; end
    end
  end

  initial begin
    int n;
    n = 0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b0; n = 0;
      end else if (M_AXI_BREADY) begin
        if (n >= b_delay) begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = b_resp; end else n++;
      end else n = 0;
    end
  end

  initial begin
    int n;
    n = 0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (M_AXI_RVALID) begin
        M_AXI_RVALID = 1'b0; n = 0;
      end else if (M_AXI_RREADY) begin
        if (n >= r_delay) begin
          M_AXI_RVALID = 1'b1; M_AXI_RDATA = r_data; M_AXI_RRESP = r_resp;
        end else n++;
      end else n = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    wrsp_t we;
    rrsp_t re;
    int    t;
    forever begin
      @(negedge clk); #1;
      if (aresetn) begin
        if (M_AXI_AWVALID) begin
          check("aw_expected", 64'(awq.size() > 0), 64'd1);
          if (awq.size() > 0) begin
            check("awaddr", 64'(M_AXI_AWADDR), 64'(awq[0]));
            check("awprot", 64'(M_AXI_AWPROT), 64'd0);
            if (M_AXI_AWREADY) void'(awq.pop_front());
          end
        end
        if (M_AXI_WVALID) begin
          check("w_expected", 64'(wq.size() > 0), 64'd1);
          if (wq.size() > 0) begin
            check("wstrb_wdata", 64'({M_AXI_WSTRB, M_AXI_WDATA}), 64'(wq[0]));
            if (M_AXI_WREADY) void'(wq.pop_front());
          end
        end
        if (M_AXI_ARVALID) begin
          check("ar_expected", 64'(arq.size() > 0), 64'd1);
          if (arq.size() > 0) begin
            check("araddr", 64'(M_AXI_ARADDR), 64'(arq[0]));
            check("arprot", 64'(M_AXI_ARPROT), 64'd0);
            if (M_AXI_ARREADY) void'(arq.pop_front());
          end
        end
        if (wr_rsp_valid) begin
          check("wr_rsp_expected", 64'(wrspq.size() > 0), 64'd1);
          if (wrspq.size() > 0) begin
            we = wrspq.pop_front();
            check("wr_rsp_resp", 64'(wr_rsp_resp), 64'(we.resp));
            if (we.lat >= 0) check("wr_rsp_latency", 64'(cyc - we.acc + 1), 64'(we.lat));
          end
        end
        if (rd_rsp_valid) begin
          check("rd_rsp_expected", 64'(rrspq.size() > 0), 64'd1);
          if (rrspq.size() > 0) begin
            re = rrspq.pop_front();
            check("rd_rsp_data", 64'(rd_rsp_data), 64'(re.data));
            check("rd_rsp_resp", 64'(rd_rsp_resp), 64'(re.resp));
            if (re.lat >= 0) check("rd_rsp_latency", 64'(cyc - re.acc + 1), 64'(re.lat));
          end
        end
        if (wr_timeout) begin
          check("wr_timeout_expected", 64'(wtoq.size() > 0), 64'd1);
          if (wtoq.size() > 0) begin
            t = wtoq.pop_front();
            check("wr_timeout_cycle", 64'(cyc), 64'(t));
          end
        end
        if (rd_timeout) begin
          check("rd_timeout_expected", 64'(rtoq.size() > 0), 64'd1);
          if (rtoq.size() > 0) begin
            t = rtoq.pop_front();
            check("rd_timeout_cycle", 64'(cyc), 64'(t));
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wr_cmd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [1:0] r, input int lat, input bit track, input bit exp_to);
    wrsp_t e;
    int    n;
    @(negedge clk);
    wr_req_valid = 1'b1; wr_req_addr = a; wr_req_data = d; wr_req_strb = s;
    n = 0;
    while (!wr_req_ready && n < 100) begin @(negedge clk); n++; end
    check("wr_req_accepted", 64'(wr_req_ready), 64'd1);
    awq.push_back(a);
    wq.push_back({s, d});
    if (track) begin
      e.resp = r; e.lat = lat; e.acc = cyc + 1;
      wrspq.push_back(e);
    end
    if (exp_to) wtoq.push_back(cyc + 1 + TO);
    @(posedge clk); #1;
    wr_req_valid = 1'b0; wr_req_addr = '1; wr_req_data = '1; wr_req_strb = '0;
  endtask

  task automatic rd_cmd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                        input int lat);
    rrsp_t e;
    int    n;
    @(negedge clk);
    rd_req_valid = 1'b1; rd_req_addr = a;
    n = 0;
    while (!rd_req_ready && n < 100) begin @(negedge clk); n++; end
    check("rd_req_accepted", 64'(rd_req_ready), 64'd1);
    arq.push_back(a);
    e.data = d; e.resp = r; e.lat = lat; e.acc = cyc + 1;
    rrspq.push_back(e);
    @(posedge clk); #1;
    rd_req_valid = 1'b0; rd_req_addr = '1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((wrspq.size() + rrspq.size() + wtoq.size()) != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    check("drained_within_budget", 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed tests ----------------
  initial begin
    aresetn = 1'b0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_strb = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                             M_AXI_RREADY, wr_rsp_valid, rd_rsp_valid, wr_timeout, rd_timeout}), 64'd0);
    check("reset_data", 64'(M_AXI_AWADDR | M_AXI_WDATA | M_AXI_ARADDR | rd_rsp_data), 64'd0);
    check("reset_misc", 64'({M_AXI_WSTRB, wr_rsp_resp, rd_rsp_resp}), 64'd0);
    check("reset_req_ready", 64'({wr_req_ready, rd_req_ready}), 64'b11);
    aresetn = 1'b1;

    // 1: zero-wait write
    wr_cmd(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 3, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_cyc1_aw_w_b", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b110);
    @(negedge clk);
    check("t1_cyc2_aw_w_b", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'b001);
    wait_done(50);

    // 2: WREADY two cycles ahead of AWREADY
    aw_delay = 2; w_delay = 0;
    wr_cmd(32'h20, 32'h0BADF00D, 4'h5, 2'b00, 5, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t2_w_dropped_first", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'b10);
    check("t2_awaddr_held", 64'(M_AXI_AWADDR), 64'h20);
    wait_done(50);
    aw_delay = 0;

    // 3: delayed read with SLVERR
    r_delay = 5; r_data = 32'h12345678; r_resp = 2'b10;
    rd_cmd(32'h40, 32'h12345678, 2'b10, 8);
    wait_done(50);
    repeat (4) @(negedge clk);
    check("t3_rd_data_held", 64'(rd_rsp_data), 64'h12345678);
    check("t3_rd_resp_held", 64'(rd_rsp_resp), 64'd2);
    r_delay = 0;

    // 4: concurrent write and read
    r_data = 32'hA5A50008; r_resp = 2'b00; b_resp = 2'b01;
    fork
      wr_cmd(32'h04, 32'hCAFEF00D, 4'h3, 2'b01, 3, 1'b1, 1'b0);
      rd_cmd(32'h08, 32'hA5A50008, 2'b00, 3);
    join
    wait_done(50);
    b_resp = 2'b00;

    // 5: BVALID withheld past the watchdog
    b_delay = 20; b_resp = 2'b11;
    wr_cmd(32'h50, 32'h600DCAFE, 4'hF, 2'b11, 23, 1'b1, 1'b1);
    wait_done(100);
    b_delay = 0; b_resp = 2'b00;

    // 6: reset in W_XFER
    aw_delay = 10; w_delay = 10;
    wr_cmd(32'h30, 32'h11112222, 4'hF, 2'b00, -1, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_in_xfer", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'b11);
    aresetn = 1'b0;
    @(negedge clk);
    check("t6_rst_ctrl", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                              M_AXI_RREADY, wr_rsp_valid, wr_timeout}), 64'd0);
    check("t6_wr_req_ready", 64'(wr_req_ready), 64'd1);
    awq.delete(); wq.delete();
    aresetn = 1'b1; aw_delay = 0; w_delay = 0;
    repeat (12) @(negedge clk);
    wr_cmd(32'h34, 32'h33334444, 4'hC, 2'b00, 3, 1'b1, 1'b0);
    wait_done(50);

    check("end_awq_empty", 64'(awq.size()), 64'd0);
    check("end_wq_empty", 64'(wq.size()), 64'd0);
    check("end_arq_empty", 64'(arq.size()), 64'd0);
    check("end_rtoq_empty", 64'(rtoq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
